// File: rtl/e_seq_if.sv
// Handshake bundle for the zero-bit enumerator: vector input side and grant output side.
interface e_seq_if #(parameter int W = 4);
   localparam int IW = $clog2(W);

   logic          in_vld_i;
   logic          in_rdy_o;
   logic [W-1:0]  in_x_i;
   logic          out_vld_o;
   logic          out_rdy_i;
   logic [W-1:0]  out_y_o;
   logic [IW-1:0] out_idx_o;
   logic          out_last_o;
   logic          empty_o;

   modport slave (
      input  in_vld_i, in_x_i, out_rdy_i,
      output in_rdy_o, out_vld_o, out_y_o, out_idx_o, out_last_o, empty_o
   );

   modport master (
      output in_vld_i, in_x_i, out_rdy_i,
      input  in_rdy_o, out_vld_o, out_y_o, out_idx_o, out_last_o, empty_o
   );
endinterface

// File: rtl/e_seq.sv
// Sequential zero-bit enumerator: walks a captured occupancy vector and grants
// each zero bit, highest first, one per accepted handshake.
//
// state | meaning
// IDLE  | waiting for a vector, in_rdy_o high
// WALK  | grant register valid, stepping down through zero bits
module e_seq #(
   parameter int W = 4
) (
   input logic    clk,
   input logic    arst_n,
   e_seq_if.slave bus
);
   localparam int IW = $clog2(W);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WALK = 1'b1;

   if (W < 2 || W > 8) begin : g_bad_width
      $error("e_seq: W must be in 2..8");
   end

   logic [0:0]    state;
   logic [W-1:0]  vec_q;
   logic [W-1:0]  grant_q;
   logic [IW-1:0] idx_q;
   logic          last_q;
   logic          empty_q;

   logic          accept;
   logic [W-1:0]  cand;
   logic [W-1:0]  nxt_grant;
   logic          nxt_last;
   logic          has_zero;

   // Bits strictly below the single set bit of g.
   function automatic logic [W-1:0] below_of(input logic [W-1:0] g);
      logic [W-1:0] b;
      logic         seen;
      b    = '0;
      seen = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         b[i] = seen;
         seen = seen | g[i];
      end
      return b;
   endfunction

   function automatic logic [W-1:0] pick_top(input logic [W-1:0] c);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         if (c[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [IW-1:0] encode(input logic [W-1:0] g);
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         if (g[i]) r = i[IW-1:0];
      end
      return r;
   endfunction

   assign bus.in_rdy_o = (state == IDLE) | ((state == WALK) & last_q & bus.out_rdy_i);
   assign accept       = bus.in_vld_i & bus.in_rdy_o;

   // A fresh accept searches the incoming vector from the top; otherwise step below the current grant.
   always_comb begin
      cand      = '0;
      nxt_grant = '0;
      nxt_last  = 1'b0;
      has_zero  = 1'b0;
      if (accept) cand = ~bus.in_x_i;
      else        cand = ~vec_q & below_of(grant_q);
      nxt_grant = pick_top(cand);
      has_zero  = |cand;
      nxt_last  = ~|(cand & below_of(nxt_grant));
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state   <= IDLE;
         vec_q   <= '1;
         grant_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         empty_q <= 1'b0;
      end else begin
         empty_q <= 1'b0;
         if (accept) begin
            vec_q <= bus.in_x_i;
            if (has_zero) begin
               state   <= WALK;
               grant_q <= nxt_grant;
               idx_q   <= encode(nxt_grant);
               last_q  <= nxt_last;
            end else begin
               state   <= IDLE;
               empty_q <= 1'b1;
               grant_q <= '0;
               idx_q   <= '0;
               last_q  <= 1'b0;
            end
         end else if (state == WALK && bus.out_rdy_i) begin
            if (last_q) begin
               state   <= IDLE;
               grant_q <= '0;
               idx_q   <= '0;
               last_q  <= 1'b0;
            end else begin
               grant_q <= nxt_grant;
               idx_q   <= encode(nxt_grant);
               last_q  <= nxt_last;
            end
         end
      end
   end

   assign bus.out_vld_o  = (state == WALK);
   assign bus.out_y_o    = grant_q;
   assign bus.out_idx_o  = idx_q;
   assign bus.out_last_o = last_q;
   assign bus.empty_o    = empty_q;
endmodule

// File: tb/tb_e_seq.sv
// Directed bench for e_seq: W=4 and W=8 instances sharing clock and reset.
module tb_e_seq;
   logic clk;
   logic arst_n;
   int   errors;
   int   checks;

   e_seq_if #(.W(4)) b4 ();
   e_seq_if #(.W(8)) b8 ();

   e_seq #(.W(4)) dut4 (.clk(clk), .arst_n(arst_n), .bus(b4));
   e_seq #(.W(8)) dut8 (.clk(clk), .arst_n(arst_n), .bus(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {vld, y, idx, last, empty} for the W=4 instance
   function automatic logic [8:0] obs4();
      return {b4.out_vld_o, b4.out_y_o, b4.out_idx_o, b4.out_last_o, b4.empty_o};
   endfunction

   task automatic test_reset();
      arst_n = 1'b0;
      #1;
      checks++;
      if (obs4() !== 9'b0_0000_00_0_0) begin
         errors++; $display("FAIL reset_outs4 got=%b exp=%b", obs4(), 9'b0_0000_00_0_0);
      end
      checks++;
      if ({b8.out_vld_o, b8.out_y_o, b8.out_idx_o, b8.out_last_o, b8.empty_o} !== 14'd0) begin
         errors++; $display("FAIL reset_outs8 got=%b exp=0", {b8.out_vld_o, b8.out_y_o, b8.out_idx_o});
      end
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (b4.in_rdy_o !== 1'b1) begin
         errors++; $display("FAIL reset_rdy got=%b exp=1", b4.in_rdy_o);
      end
   endtask

   task automatic test_basic();
      b4.in_vld_i = 1'b1; b4.in_x_i = 4'b0101; b4.out_rdy_i = 1'b1;
      @(negedge clk);
      b4.in_vld_i = 1'b0;
      checks++;
      if (obs4() !== 9'b1_1000_11_0_0) begin
         errors++; $display("FAIL basic_g0 got=%b exp=%b", obs4(), 9'b1_1000_11_0_0);
      end
      @(negedge clk);
      checks++;
      if (obs4() !== 9'b1_0010_01_1_0) begin
         errors++; $display("FAIL basic_g1 got=%b exp=%b", obs4(), 9'b1_0010_01_1_0);
      end
      @(negedge clk);
      checks++;
      if ({obs4(), b4.in_rdy_o} !== 10'b0_0000_00_0_0_1) begin
         errors++; $display("FAIL basic_idle got=%b exp=%b", {obs4(), b4.in_rdy_o}, 10'b0_0000_00_0_0_1);
      end
   endtask

   task automatic test_empty();
      b4.in_vld_i = 1'b1; b4.in_x_i = 4'b1111;
      @(negedge clk);
      b4.in_vld_i = 1'b0;
      checks++;
      if ({obs4(), b4.in_rdy_o} !== 10'b0_0000_00_0_1_1) begin
         errors++; $display("FAIL empty_pulse got=%b exp=%b", {obs4(), b4.in_rdy_o}, 10'b0_0000_00_0_1_1);
      end
      @(negedge clk);
      checks++;
      if ({obs4(), b4.in_rdy_o} !== 10'b0_0000_00_0_0_1) begin
         errors++; $display("FAIL empty_clear got=%b exp=%b", {obs4(), b4.in_rdy_o}, 10'b0_0000_00_0_0_1);
      end
   endtask

   task automatic test_w8_full();
      logic [7:0] exp_y;
      logic [2:0] exp_idx;
      b8.in_vld_i = 1'b1; b8.in_x_i = 8'h00; b8.out_rdy_i = 1'b1;
      exp_y = 8'h80;
      exp_idx = 3'd7;
      @(negedge clk);
      b8.in_vld_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({b8.out_vld_o, b8.out_y_o, b8.out_idx_o, b8.out_last_o} !== {1'b1, exp_y, exp_idx, (k == 7)}) begin
            errors++;
            $display("FAIL w8_grant%0d got vld=%b y=%h idx=%0d last=%b exp y=%h idx=%0d last=%b", k,
                     b8.out_vld_o, b8.out_y_o, b8.out_idx_o, b8.out_last_o, exp_y, exp_idx, (k == 7));
         end
         exp_y   = exp_y >> 1;
         exp_idx = exp_idx - 3'd1;
         @(negedge clk);
      end
      checks++;
      if ({b8.out_vld_o, b8.in_rdy_o} !== 2'b01) begin
         errors++; $display("FAIL w8_idle got vld,rdy=%b exp=01", {b8.out_vld_o, b8.in_rdy_o});
      end
   endtask

   task automatic test_stall();
      b4.in_vld_i = 1'b1; b4.in_x_i = 4'b0011; b4.out_rdy_i = 1'b0;
      @(negedge clk);
      b4.in_vld_i = 1'b0;
      b4.in_x_i = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs4() !== 9'b1_1000_11_0_0) begin
            errors++; $display("FAIL stall_hold%0d got=%b exp=%b", k, obs4(), 9'b1_1000_11_0_0);
         end
         if (k == 2) b4.out_rdy_i = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (obs4() !== 9'b1_0100_10_1_0) begin
         errors++; $display("FAIL stall_next got=%b exp=%b", obs4(), 9'b1_0100_10_1_0);
      end
      @(negedge clk);
      checks++;
      if (b4.out_vld_o !== 1'b0) begin
         errors++; $display("FAIL stall_done got=%b exp=0", b4.out_vld_o);
      end
   endtask

   task automatic test_back_to_back();
      b4.in_vld_i = 1'b1; b4.in_x_i = 4'b0101; b4.out_rdy_i = 1'b1;
      @(negedge clk);
      b4.in_x_i = 4'b1110;
      checks++;
      if (b4.in_rdy_o !== 1'b0) begin
         errors++; $display("FAIL b2b_rdy_mid got=%b exp=0", b4.in_rdy_o);
      end
      @(negedge clk);
      checks++;
      if ({obs4(), b4.in_rdy_o} !== 10'b1_0010_01_1_0_1) begin
         errors++; $display("FAIL b2b_last got=%b exp=%b", {obs4(), b4.in_rdy_o}, 10'b1_0010_01_1_0_1);
      end
      @(negedge clk);
      b4.in_x_i = 4'b0111;
      checks++;
      if (obs4() !== 9'b1_0001_00_1_0) begin
         errors++; $display("FAIL b2b_second got=%b exp=%b", obs4(), 9'b1_0001_00_1_0);
      end
      @(negedge clk);
      b4.in_x_i = 4'b1111;
      checks++;
      if (obs4() !== 9'b1_1000_11_1_0) begin
         errors++; $display("FAIL b2b_third got=%b exp=%b", obs4(), 9'b1_1000_11_1_0);
      end
      @(negedge clk);
      b4.in_vld_i = 1'b0;
      checks++;
      if ({obs4(), b4.in_rdy_o} !== 10'b0_0000_00_0_1_1) begin
         errors++; $display("FAIL b2b_empty got=%b exp=%b", {obs4(), b4.in_rdy_o}, 10'b0_0000_00_0_1_1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_walk();
      b4.in_vld_i = 1'b1; b4.in_x_i = 4'b0000; b4.out_rdy_i = 1'b1;
      @(negedge clk);
      b4.in_vld_i = 1'b0;
      checks++;
      if (obs4() !== 9'b1_1000_11_0_0) begin
         errors++; $display("FAIL rst_mid_g0 got=%b exp=%b", obs4(), 9'b1_1000_11_0_0);
      end
      @(negedge clk);
      checks++;
      if (obs4() !== 9'b1_0100_10_0_0) begin
         errors++; $display("FAIL rst_mid_g1 got=%b exp=%b", obs4(), 9'b1_0100_10_0_0);
      end
      arst_n = 1'b0;
      #1;
      checks++;
      if (obs4() !== 9'b0_0000_00_0_0) begin
         errors++; $display("FAIL rst_mid_async got=%b exp=0", obs4());
      end
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (b4.in_rdy_o !== 1'b1) begin
         errors++; $display("FAIL rst_mid_rdy got=%b exp=1", b4.in_rdy_o);
      end
      b4.in_vld_i = 1'b1; b4.in_x_i = 4'b0000;
      @(negedge clk);
      b4.in_vld_i = 1'b0;
      checks++;
      if (obs4() !== 9'b1_1000_11_0_0) begin
         errors++; $display("FAIL rst_mid_restart got=%b exp=%b", obs4(), 9'b1_1000_11_0_0);
      end
      b4.out_rdy_i = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      b4.in_vld_i = 1'b0; b4.in_x_i = '0; b4.out_rdy_i = 1'b0;
      b8.in_vld_i = 1'b0; b8.in_x_i = '0; b8.out_rdy_i = 1'b0;
      arst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_empty();
      test_w8_full();
      test_stall();
      test_back_to_back();
      test_reset_mid_walk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/e_seq.md
# e_seq

Sequential zero-bit enumerator. Accepts a W-bit occupancy vector and emits, one per handshake, a one-hot grant for each zero bit in descending bit order (W-1 down to 0). It is the driver side of the codebase's next-free-position selection: it holds the current selection and the "start from top" state as registers, and walks a vector to exhaustion. Downstream allocators use it to hand out free slots one at a time.

## Interface
- W, default 4: vector width. Supported range is 2..8. Any other value is an elaboration-time `$error`.
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- in_vld_i  in  1  input vector valid.
- in_rdy_o  out  1  block can accept a vector.
- in_x_i  in  W  occupancy vector. 1 = skip, 0 = candidate.
- out_vld_o  out  1  grant valid.
- out_rdy_i  in  1  consumer accepts the grant.
- out_y_o  out  W  one-hot grant. All zeros when out_vld_o=0.
- out_idx_o  out  $clog2(W)  binary bit position of out_y_o. 0 when out_vld_o=0.
- out_last_o  out  1  current grant is the lowest zero bit of the captured vector.
- empty_o  out  1  one-cycle pulse: the accepted vector had no zero bits.

## Operation
- The FSM has two states: IDLE and WALK. Reset value is IDLE.
- Reset values:
  - out_vld_o=0, out_y_o=0, out_idx_o=0, out_last_o=0, empty_o=0.
  - in_rdy_o=1 once arst_n deasserts.
  - Captured vector register = all ones.
- IDLE:
  - in_rdy_o=1.
  - On in_vld_i & in_rdy_o, capture in_x_i.
  - If in_x_i is all ones: assert empty_o for the next cycle and stay in IDLE.
  - Otherwise: go to WALK. Load the grant register with the highest zero bit of in_x_i. Set last = (no zero below that bit).
- WALK:
  - out_vld_o=1. out_y_o, out_idx_o and out_last_o come from registers.
  - On out_rdy_i with out_last_o=0: load the next zero strictly below the current position. Recompute last for the new position.
  - On out_rdy_i with out_last_o=1: the walk is complete. Return to IDLE, or reload directly if a vector is accepted in the same cycle (see back-to-back).
- Search logic:
  - Priority search on the captured vector, masked to bits below the current position.
  - "Start from top" search means the mask is all ones.
  - No arithmetic beyond the one-hot to binary encode of out_idx_o.
- Back-to-back:
  - in_rdy_o = IDLE | (WALK & out_last_o & out_rdy_i). This combinational out_rdy_i→in_rdy_o path is intentional.
  - On that simultaneous completion + accept, the new vector is captured. Its first grant is valid the next cycle, with no IDLE bubble.
  - If that new vector is all ones: go to IDLE and pulse empty_o.
- Stall: while out_vld_o & !out_rdy_i, out_y_o, out_idx_o and out_last_o hold stable. in_x_i is ignored.
- in_x_i is sampled only on acceptance. Later changes do not affect an active walk.
- Asynchronous reset mid-walk: the block returns to the reset values immediately. The partial walk is discarded. There is no resumption.

## Timing
- Vector accepted at edge N → first grant visible after edge N (cycle N+1). Latency is 1 cycle.
- Throughput is one grant per cycle when out_rdy_i is held high.
- A vector with k zero bits occupies WALK for exactly k cycles with no stall.
- empty_o is high for exactly the one cycle after acceptance.
- empty_o and out_vld_o are never high together, except when empty follows a back-to-back accept. In that case out_vld_o is already 0.
- All outputs are registered except in_rdy_o.

## Test plan
- W=4, in_x_i=4'b0101, out_rdy_i=1 → grant 4'b1000 (idx 3, last 0), then next cycle 4'b0010 (idx 1, last 1), then IDLE.
- W=4, in_x_i=4'b1111 → empty_o pulses one cycle. out_vld_o stays 0. in_rdy_o stays 1.
- W=8, in_x_i=8'h00 → 8 consecutive grants 8'h80 down to 8'h01. out_last_o is set only on 8'h01.
- W=4, in_x_i=4'b0011, out_rdy_i low for 3 cycles → 4'b1000 held stable for 3 cycles, then 4'b0100 with last=1.
- Back-to-back: second vector 4'b1110 offered during the last grant of the first → next cycle grant 4'b0001 (last 1). No idle cycle between walks.
- Reset asserted mid-walk of 4'b0000 after 2 grants → outputs go to 0 immediately. After release, in_rdy_o=1 and a new vector starts from bit 3.
